// File: rtl/change_dispenser.sv
// Coin-output end of the vending machine change path: greedy payout through a
// hopper with eject/ack handshake, per-denomination inventory and fault flags.
module change_dispenser #(
    parameter int WIDTH        = 16,
    parameter int CNT_W        = 8,
    parameter int DOLLAR_INIT  = 20,
    parameter int QUARTER_INIT = 40,
    parameter int DIME_INIT    = 40,
    parameter int NICKEL_INIT  = 40,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] change_in,
    input  logic             change_valid,
    input  logic             hopper_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_type,
    input  logic [CNT_W-1:0] refill_count,
    output logic             busy,
    output logic             coin_eject,
    output logic [1:0]       coin_type,
    output logic [WIDTH-1:0] remaining,
    output logic             done,
    output logic             short_change,
    output logic             jam,
    output logic [CNT_W-1:0] inv_dollar,
    output logic [CNT_W-1:0] inv_quarter,
    output logic [CNT_W-1:0] inv_dime,
    output logic [CNT_W-1:0] inv_nickel
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        WAIT_ACK,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] remaining_q;
    logic [1:0]       coinType_q;
    logic             coinEject_q;
    logic             done_q;
    logic             short_q;
    logic             jam_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] inv_q [4];
    logic [CNT_W-1:0] inv_d [4];
    logic [CNT_W:0]   sum_d [4];

    logic             found;
    logic [1:0]       pick;
    logic             ackTake;

    function automatic logic [WIDTH-1:0] coinValue(input logic [1:0] t);
        case (t)
            2'd0:    coinValue = WIDTH'(100);
            2'd1:    coinValue = WIDTH'(25);
            2'd2:    coinValue = WIDTH'(10);
            default: coinValue = WIDTH'(5);
        endcase
    endfunction

    assign ackTake = (state_q == WAIT_ACK) && hopper_ack;

    // Largest coin that fits the amount owed and is still in stock.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        if (remaining_q >= WIDTH'(100) && inv_q[0] != '0) begin
            found = 1'b1;
            pick  = 2'd0;
        end else if (remaining_q >= WIDTH'(25) && inv_q[1] != '0) begin
            found = 1'b1;
            pick  = 2'd1;
        end else if (remaining_q >= WIDTH'(10) && inv_q[2] != '0) begin
            found = 1'b1;
            pick  = 2'd2;
        end else if (remaining_q >= WIDTH'(5) && inv_q[3] != '0) begin
            found = 1'b1;
            pick  = 2'd3;
        end
    end

    // A taken coin always had stock > 0, so the sum never goes below zero.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sum_d[k] = {1'b0, inv_q[k]};
            if (refill_valid && refill_type == 2'(k))
                sum_d[k] = sum_d[k] + {1'b0, refill_count};
            if (ackTake && coinType_q == 2'(k))
                sum_d[k] = sum_d[k] - (CNT_W+1)'(1);
            inv_d[k] = sum_d[k][CNT_W] ? {CNT_W{1'b1}} : sum_d[k][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inv_q[0] <= CNT_W'(DOLLAR_INIT);
            inv_q[1] <= CNT_W'(QUARTER_INIT);
            inv_q[2] <= CNT_W'(DIME_INIT);
            inv_q[3] <= CNT_W'(NICKEL_INIT);
        end else begin
            for (int k = 0; k < 4; k++)
                inv_q[k] <= inv_d[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coinType_q  <= 2'd0;
            coinEject_q <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            jam_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            coinEject_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (change_valid) begin
                        remaining_q <= change_in;
                        short_q     <= 1'b0;
                        jam_q       <= 1'b0;
                        if (change_in == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    if (found) begin
                        coinType_q  <= pick;
                        coinEject_q <= 1'b1;
                        state_q     <= EJECT;
                    end else begin
                        short_q <= (remaining_q != '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                EJECT: begin
                    timer_q <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (hopper_ack) begin
                        remaining_q <= remaining_q - coinValue(coinType_q);
                        if (remaining_q == coinValue(coinType_q)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= SELECT;
                        end
                    end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                        jam_q   <= 1'b1;
                        short_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign coin_eject   = coinEject_q;
    assign coin_type    = coinType_q;
    assign remaining    = remaining_q;
    assign done         = done_q;
    assign short_change = short_q;
    assign jam          = jam_q;
    assign inv_dollar   = inv_q[0];
    assign inv_quarter  = inv_q[1];
    assign inv_dime     = inv_q[2];
    assign inv_nickel   = inv_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances with different stock
// loads, an auto-acking hopper model, a vector table and hand-built sequences.
module tb_change_dispenser;

    localparam int NDUT = 3;
    localparam int QI [NDUT] = '{40, 0, 40};
    localparam int DI [NDUT] = '{40, 40, 0};
    localparam int NI [NDUT] = '{40, 40, 0};

    logic        clk;
    logic        resetN;
    logic [15:0] changeIn;
    logic        changeValid;
    logic        manualAck;
    logic        autoAck;
    logic        ackEn;
    logic        refillValid;
    logic [1:0]  refillType;
    logic [7:0]  refillCount;
    int          sel;

    logic        cvG      [NDUT];
    logic        ackG     [NDUT];
    logic        rvG      [NDUT];
    logic        busyA    [NDUT];
    logic        ejectA   [NDUT];
    logic [1:0]  typeA    [NDUT];
    logic [15:0] remA     [NDUT];
    logic        doneA    [NDUT];
    logic        shortA   [NDUT];
    logic        jamA     [NDUT];
    logic [7:0]  invDA    [NDUT];
    logic [7:0]  invQA    [NDUT];
    logic [7:0]  invDiA   [NDUT];
    logic [7:0]  invNA    [NDUT];

    int          compared;
    int          mismatched;
    int          hopCnt;
    logic [1:0]  ejLog [$];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        assign cvG[g]  = changeValid && (sel == g);
        assign ackG[g] = (autoAck || manualAck) && (sel == g);
        assign rvG[g]  = refillValid && (sel == g);

        change_dispenser #(
            .WIDTH(16), .CNT_W(8), .DOLLAR_INIT(20), .QUARTER_INIT(QI[g]),
            .DIME_INIT(DI[g]), .NICKEL_INIT(NI[g]), .ACK_TIMEOUT(16)
        ) dut (
            .clk(clk), .reset(resetN), .change_in(changeIn), .change_valid(cvG[g]),
            .hopper_ack(ackG[g]), .refill_valid(rvG[g]), .refill_type(refillType),
            .refill_count(refillCount), .busy(busyA[g]), .coin_eject(ejectA[g]),
            .coin_type(typeA[g]), .remaining(remA[g]), .done(doneA[g]),
            .short_change(shortA[g]), .jam(jamA[g]), .inv_dollar(invDA[g]),
            .inv_quarter(invQA[g]), .inv_dime(invDiA[g]), .inv_nickel(invNA[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hopper model: logs every eject of the selected unit and acks it three cycles later.
    always @(negedge clk) begin
        autoAck = 1'b0;
        if (hopCnt > 0) begin
            hopCnt = hopCnt - 1;
            if (hopCnt == 0) autoAck = 1'b1;
        end
        if (ejectA[sel]) begin
            ejLog.push_back(typeA[sel]);
            if (ackEn) hopCnt = 3;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int amount);
        @(negedge clk);
        changeIn    = 16'(amount);
        changeValid = 1'b1;
        @(negedge clk);
        changeValid = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (!doneA[sel] && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("doneSeen", int'(doneA[sel]), 1);
    endtask

    function automatic logic [31:0] invOf(input int d);
        return {invDA[d], invQA[d], invDiA[d], invNA[d]};
    endfunction

    typedef struct {
        int          dut;
        int          amount;
        int          nEj;
        logic [11:0] ejSeq;
        int          expRem;
        int          expShort;
        int          expCyc;
        logic [31:0] expInv;
    } vec_t;

    vec_t vecs [7];
    int   cyc;
    int   cnt;
    bit   doneSeen;

    initial begin
        compared    = 0;
        mismatched  = 0;
        hopCnt      = 0;
        autoAck     = 1'b0;
        manualAck   = 1'b0;
        ackEn       = 1'b1;
        sel         = 0;
        changeIn    = '0;
        changeValid = 1'b0;
        refillValid = 1'b0;
        refillType  = 2'd0;
        refillCount = '0;
        resetN      = 1'b0;

        vecs[0] = '{dut:0, amount:50,  nEj:2, ejSeq:12'({2'd1, 2'd1}), expRem:0, expShort:0,
                    expCyc:10, expInv:{8'd20, 8'd38, 8'd40, 8'd40}};
        vecs[1] = '{dut:0, amount:190, nEj:6, ejSeq:{2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0},
                    expRem:0, expShort:0, expCyc:-1, expInv:{8'd19, 8'd35, 8'd39, 8'd39}};
        vecs[2] = '{dut:0, amount:7,   nEj:1, ejSeq:12'(2'd3), expRem:2, expShort:1,
                    expCyc:6, expInv:{8'd19, 8'd35, 8'd39, 8'd38}};
        vecs[3] = '{dut:0, amount:0,   nEj:0, ejSeq:12'd0, expRem:0, expShort:0,
                    expCyc:0, expInv:{8'd19, 8'd35, 8'd39, 8'd38}};
        vecs[4] = '{dut:0, amount:37,  nEj:2, ejSeq:12'({2'd2, 2'd1}), expRem:2, expShort:1,
                    expCyc:-1, expInv:{8'd19, 8'd34, 8'd38, 8'd38}};
        vecs[5] = '{dut:1, amount:50,  nEj:5, ejSeq:12'({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}),
                    expRem:0, expShort:0, expCyc:-1, expInv:{8'd20, 8'd0, 8'd35, 8'd40}};
        vecs[6] = '{dut:2, amount:15,  nEj:0, ejSeq:12'd0, expRem:15, expShort:1,
                    expCyc:1, expInv:{8'd20, 8'd40, 8'd0, 8'd0}};

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", int'(busyA[0]), 0);
        checkOutput("rstRemaining", int'(remA[0]), 0);
        checkOutput("rstDone", int'(doneA[0]), 0);
        checkOutput("rstInv", int'(invOf(0)), int'({8'd20, 8'd40, 8'd40, 8'd40}));
        resetN = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].dut;
            ejLog.delete();
            applyStimulus(vecs[v].amount);
            checkOutput($sformatf("v%0d.busy", v), int'(busyA[sel]), 1);
            waitDone(400, cyc);
            if (vecs[v].expCyc >= 0)
                checkOutput($sformatf("v%0d.cycles", v), cyc, vecs[v].expCyc);
            checkOutput($sformatf("v%0d.ejCount", v), ejLog.size(), vecs[v].nEj);
            for (int i = 0; i < vecs[v].nEj && i < ejLog.size(); i++)
                checkOutput($sformatf("v%0d.ejType%0d", v, i), int'(ejLog[i]),
                            int'(vecs[v].ejSeq[2*i +: 2]));
            checkOutput($sformatf("v%0d.remaining", v), int'(remA[sel]), vecs[v].expRem);
            checkOutput($sformatf("v%0d.short", v), int'(shortA[sel]), vecs[v].expShort);
            checkOutput($sformatf("v%0d.jam", v), int'(jamA[sel]), 0);
            checkOutput($sformatf("v%0d.inv", v), int'(invOf(sel)), int'(vecs[v].expInv));
            @(negedge clk);
            checkOutput($sformatf("v%0d.donePulse", v), int'(doneA[sel]), 0);
            checkOutput($sformatf("v%0d.idle", v), int'(busyA[sel]), 0);
        end

        // First-eject latency: strobe edge N, eject in the cycle after N+1.
        sel = 0;
        ejLog.delete();
        applyStimulus(10);
        checkOutput("lat.noEjectYet", int'(ejectA[0]), 0);
        @(negedge clk);
        checkOutput("lat.eject", int'(ejectA[0]), 1);
        checkOutput("lat.type", int'(typeA[0]), 2);
        @(negedge clk);
        checkOutput("lat.ejectOneCycle", int'(ejectA[0]), 0);
        checkOutput("lat.typeHeld", int'(typeA[0]), 2);
        waitDone(50, cyc);
        checkOutput("lat.invDime", int'(invDiA[0]), 37);
        @(negedge clk);

        // Hopper jam with an ignored second strobe mid-wait.
        ackEn = 1'b0;
        applyStimulus(100);
        cnt = 0;
        while (!doneA[0] && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (cnt == 5) begin
                changeIn    = 16'd100;
                changeValid = 1'b1;
            end else if (cnt == 6) begin
                changeValid = 1'b0;
            end
        end
        checkOutput("jam.cycles", cnt, 18);
        checkOutput("jam.jam", int'(jamA[0]), 1);
        checkOutput("jam.short", int'(shortA[0]), 1);
        checkOutput("jam.remaining", int'(remA[0]), 100);
        checkOutput("jam.invDollar", int'(invDA[0]), 19);
        @(negedge clk);
        checkOutput("jam.noRequeue", int'(busyA[0]), 0);
        checkOutput("jam.held", int'(jamA[0]), 1);

        // New payout clears the flags; reset after the first ack abandons it.
        ackEn = 1'b1;
        applyStimulus(75);
        checkOutput("clr.jam", int'(jamA[0]), 0);
        checkOutput("clr.short", int'(shortA[0]), 0);
        cnt = 0;
        while (invQA[0] != 8'd33 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("rst2.firstAck", int'(invQA[0]), 33);
        checkOutput("rst2.remainingBefore", int'(remA[0]), 50);
        resetN = 1'b0;
        #1;
        checkOutput("rst2.busy", int'(busyA[0]), 0);
        checkOutput("rst2.remaining", int'(remA[0]), 0);
        checkOutput("rst2.eject", int'(ejectA[0]), 0);
        checkOutput("rst2.inv", int'(invOf(0)), int'({8'd20, 8'd40, 8'd40, 8'd40}));
        doneSeen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) resetN = 1'b1;
            if (doneA[0] || ejectA[0]) doneSeen = 1'b1;
        end
        checkOutput("rst2.noDone", int'(doneSeen), 0);
        hopCnt = 0;

        // Refill and ack of the same denomination on the same edge.
        ackEn = 1'b0;
        ejLog.delete();
        applyStimulus(25);
        @(negedge clk);
        checkOutput("racc.eject", int'(ejectA[0]), 1);
        @(negedge clk);
        manualAck   = 1'b1;
        refillValid = 1'b1;
        refillType  = 2'd1;
        refillCount = 8'd5;
        @(negedge clk);
        manualAck   = 1'b0;
        refillValid = 1'b0;
        checkOutput("racc.invQuarter", int'(invQA[0]), 44);
        checkOutput("racc.remaining", int'(remA[0]), 0);
        checkOutput("racc.done", int'(doneA[0]), 1);
        @(negedge clk);

        // Refill saturation while idle.
        refillValid = 1'b1;
        refillType  = 2'd3;
        refillCount = 8'd250;
        @(negedge clk);
        refillValid = 1'b0;
        checkOutput("sat.invNickel", int'(invNA[0]), 255);
        checkOutput("sat.invDime", int'(invDiA[0]), 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-output end of the vending machine's `change` interface.
- Accepts a change amount in cents with a one-cycle strobe.
- Pays the amount out greedily, one coin at a time, through a coin hopper with an eject/ack handshake, and tracks per-denomination coin inventory.
- Reports completion, shortfall (not enough coins / non-payable residue) and hopper jam.

Parameters:
- WIDTH, 16, width of change amount and remaining (cents)
- CNT_W, 8, width of each inventory counter
- DOLLAR_INIT, 20, dollar coins loaded at reset
- QUARTER_INIT, 40, quarters loaded at reset
- DIME_INIT, 40, dimes loaded at reset
- NICKEL_INIT, 40, nickels loaded at reset
- ACK_TIMEOUT, 16, max cycles to wait for hopper_ack before declaring jam

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- change_in  input  WIDTH  amount to pay out, cents
- change_valid  input  1  one-cycle strobe qualifying change_in
- hopper_ack  input  1  hopper finished ejecting the requested coin
- refill_valid  input  1  add coins to inventory this cycle
- refill_type  input  2  0=$1.00, 1=25c, 2=10c, 3=5c
- refill_count  input  CNT_W  coins added
- busy  output  1  payout in progress (state != IDLE)
- coin_eject  output  1  one-cycle request to hopper
- coin_type  output  2  denomination for coin_eject (same encoding as refill_type)
- remaining  output  WIDTH  cents still owed
- done  output  1  one-cycle pulse at end of payout
- short_change  output  1  payout ended with remaining != 0; held until next accepted change_valid
- jam  output  1  hopper timeout occurred; held until next accepted change_valid
- inv_dollar, inv_quarter, inv_dime, inv_nickel  output  CNT_W each  current inventory

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0 except inventories.
  - Inventories load their *_INIT values.
  - Payout in flight is abandoned; no done pulse.
- States: IDLE, SELECT, EJECT, WAIT_ACK, DONE.
- IDLE:
  - change_valid=1 latches change_in into remaining, clears short_change and jam, goes to SELECT.
  - change_in=0 goes straight to DONE.
- SELECT (1 cycle): choose the largest denomination with value <= remaining and inventory > 0, in the order 100, 25, 10, 5.
  - If one is found: latch coin_type, go to EJECT.
  - If none is found: go to DONE. short_change = (remaining != 0).
- EJECT (1 cycle): coin_eject=1 with coin_type stable; go to WAIT_ACK and reset the timeout counter.
- WAIT_ACK:
  - coin_type is held.
  - On hopper_ack=1: decrement that inventory and subtract the coin value from remaining (same edge). Go to DONE if remaining becomes 0, else SELECT.
  - If ACK_TIMEOUT cycles elapse without ack: jam=1, short_change=1, go to DONE. Inventory and remaining are unchanged.
- DONE (1 cycle): done=1, then IDLE.
- Latency:
  - change_valid at edge N → first coin_eject in the cycle after edge N+1.
  - Each coin costs 2 + (ack delay) cycles.
- change_valid while busy: ignored; no queueing.
- hopper_ack outside WAIT_ACK: ignored.
- Amounts not a multiple of 5: paid down to the residue (<5), then short_change=1 with remaining = residue.
- Refill:
  - Accepted in any state; the new count is visible on the next cycle.
  - Saturates at 2^CNT_W-1.
  - Refill and ack on the same type in the same cycle: net result is +refill_count-1, saturated.
  - A refill arriving during SELECT affects the next SELECT only.
- remaining never underflows: a coin is chosen only if its value <= remaining.

Test Plan:
- Inventories at default, change_in=50 → two ejects of type 1 (each acked 3 cycles later), remaining 50→25→0, done, short_change=0, inv_quarter=38.
- change_in=190 → eject sequence types 0,1,1,1,2,3; remaining ends at 0; inv_dollar=19.
- QUARTER_INIT=0, change_in=50 → five type-2 ejects, remaining 0, short_change=0.
- DIME_INIT=0, NICKEL_INIT=0, change_in=15 → no eject, done 2 cycles after strobe, short_change=1, remaining=15. Then change_in=7 with default inventory → one nickel, remaining=2, short_change=1.
- change_in=100, hopper_ack never asserted → after ACK_TIMEOUT=16 cycles jam=1, short_change=1, remaining=100, inv_dollar unchanged. A second change_valid=100 issued mid-wait is ignored.
- change_in=75, reset pulsed low after first ack → outputs 0 immediately, inventories back to INIT, no done. refill_valid type 3 count 250 with NICKEL_INIT=40 → inv_nickel=255 (saturated).
